// File: rtl/l2_miss_ctrl_if.sv
// Bundle of request, DRAM and refill signals for the L2 miss controller.
// The controller uses the slave view; slices and the DRAM model use the master view.
interface l2_miss_ctrl_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 64,
    parameter int MSHR_DEPTH = 4
);
    localparam int IDW = $clog2(MSHR_DEPTH);

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS-1:0]            req_ready;

    logic                            dram_req_valid;
    logic                            dram_req_ready;
    logic [ADDR_WIDTH-1:0]           dram_req_addr;
    logic [IDW-1:0]                  dram_req_id;

    logic                            dram_rsp_valid;
    logic [IDW-1:0]                  dram_rsp_id;
    logic [DATA_WIDTH-1:0]           dram_rsp_data;

    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [ADDR_WIDTH-1:0]           rsp_addr;
    logic [DATA_WIDTH-1:0]           rsp_data;

    logic                            mshr_full;
    logic                            err;

    modport slave (
        input  req_valid, req_addr, dram_req_ready,
        input  dram_rsp_valid, dram_rsp_id, dram_rsp_data,
        output req_ready, dram_req_valid, dram_req_addr, dram_req_id,
        output rsp_valid, rsp_addr, rsp_data, mshr_full, err
    );

    modport master (
        output req_valid, req_addr, dram_req_ready,
        output dram_rsp_valid, dram_rsp_id, dram_rsp_data,
        input  req_ready, dram_req_valid, dram_req_addr, dram_req_id,
        input  rsp_valid, rsp_addr, rsp_data, mshr_full, err
    );
endinterface

// File: rtl/l2_miss_ctrl.sv
// Multi-port L2 miss controller: round-robin request arbitration, MSHR table with
// same-line merging, one DRAM read per line, refill broadcast to all waiting ports.
module l2_miss_ctrl #(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_WIDTH  = 40,
    parameter int DATA_WIDTH  = 64,
    parameter int LINE_OFFSET = 6,
    parameter int MSHR_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    l2_miss_ctrl_if.slave bus
);
    localparam int IDW = $clog2(MSHR_DEPTH);
    localparam int LW  = ADDR_WIDTH - LINE_OFFSET;
    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } issue_state_t;

    logic [MSHR_DEPTH-1:0] ent_valid_reg;
    logic [MSHR_DEPTH-1:0] ent_issued_reg;
    logic [LW-1:0]         ent_line_reg    [MSHR_DEPTH];
    logic [NUM_PORTS-1:0]  ent_waiters_reg [MSHR_DEPTH];

    logic [PW-1:0]         rr_ptr_reg, rr_ptr_next;
    issue_state_t          state_reg, state_next;
    logic [IDW-1:0]        issue_idx_reg, issue_idx_next;
    logic [LW-1:0]         issue_line_reg, issue_line_next;

    logic [NUM_PORTS-1:0]  rsp_valid_reg;
    logic [LW-1:0]         rsp_line_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic                  err_reg;

    logic                  rsp_hit;
    logic [MSHR_DEPTH-1:0] retire_vec;
    logic                  any_free;
    logic [IDW-1:0]        alloc_idx;
    logic [MSHR_DEPTH-1:0] pending_vec;
    logic                  pend_any;
    logic [IDW-1:0]        pend_idx;
    logic                  issue_ack;

    logic [NUM_PORTS-1:0][LW-1:0]         port_line;
    logic [NUM_PORTS-1:0][MSHR_DEPTH-1:0] port_match;
    logic [NUM_PORTS-1:0]                 grantable;
    logic [NUM_PORTS*LINE_OFFSET-1:0]     unused_offset_bits;

    logic                  grant_en;
    logic [PW-1:0]         grant_port;
    logic [PW-1:0]         cand;
    logic [LW-1:0]         grant_line;
    logic [NUM_PORTS-1:0]  grant_onehot;
    logic                  merge_hit;
    logic [IDW-1:0]        merge_idx;
    logic                  merge_en;
    logic                  alloc_en;

    // A refill retires its entry only if that entry is live and its DRAM read was accepted.
    always_comb begin
        retire_vec = '0;
        rsp_hit    = bus.dram_rsp_valid && ent_valid_reg[bus.dram_rsp_id]
                     && ent_issued_reg[bus.dram_rsp_id];
        if (rsp_hit) begin
            retire_vec[bus.dram_rsp_id] = 1'b1;
        end
    end

    // Free means invalid at the start of the cycle, so a retiring entry is never reused early.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int e = MSHR_DEPTH - 1; e >= 0; e--) begin
            if (!ent_valid_reg[e]) begin
                any_free  = 1'b1;
                alloc_idx = IDW'(e);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign port_line[gi] = bus.req_addr[gi*ADDR_WIDTH+LINE_OFFSET +: LW];
        assign unused_offset_bits[gi*LINE_OFFSET +: LINE_OFFSET] =
            bus.req_addr[gi*ADDR_WIDTH +: LINE_OFFSET];
        for (genvar gj = 0; gj < MSHR_DEPTH; gj++) begin : g_ent
            assign port_match[gi][gj] = ent_valid_reg[gj] && !retire_vec[gj]
                                        && (ent_line_reg[gj] == port_line[gi]);
        end
        assign grantable[gi] = bus.req_valid[gi] && ((|port_match[gi]) || any_free);
    end

    // Rotating search starting at rr_ptr; ports that cannot be served are skipped.
    always_comb begin
        grant_en   = 1'b0;
        grant_port = '0;
        cand       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = PW'((int'(rr_ptr_reg) + k) % NUM_PORTS);
            if (!grant_en && grantable[cand]) begin
                grant_en   = 1'b1;
                grant_port = cand;
            end
        end
    end

    always_comb begin
        grant_line   = port_line[grant_port];
        merge_hit    = 1'b0;
        merge_idx    = '0;
        grant_onehot = '0;
        for (int e = MSHR_DEPTH - 1; e >= 0; e--) begin
            if (port_match[grant_port][e]) begin
                merge_hit = 1'b1;
                merge_idx = IDW'(e);
            end
        end
        if (grant_en) begin
            grant_onehot[grant_port] = 1'b1;
        end
    end

    assign merge_en = grant_en && merge_hit;
    assign alloc_en = grant_en && !merge_hit;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_en) begin
            rr_ptr_next = PW'((int'(grant_port) + 1) % NUM_PORTS);
        end
    end

    assign pending_vec = ent_valid_reg & ~ent_issued_reg;

    always_comb begin
        pend_any = 1'b0;
        pend_idx = '0;
        for (int e = MSHR_DEPTH - 1; e >= 0; e--) begin
            if (pending_vec[e]) begin
                pend_any = 1'b1;
                pend_idx = IDW'(e);
            end
        end
    end

    // Issue FSM: the target is latched on entry to REQ so address/id stay frozen under backpressure.
    always_comb begin
        state_next      = state_reg;
        issue_idx_next  = issue_idx_reg;
        issue_line_next = issue_line_reg;
        case (state_reg)
            IDLE: begin
                if (pend_any) begin
                    state_next      = REQ;
                    issue_idx_next  = pend_idx;
                    issue_line_next = ent_line_reg[pend_idx];
                end
            end
            REQ: begin
                if (bus.dram_req_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign issue_ack = (state_reg == REQ) && bus.dram_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid_reg  <= '0;
            ent_issued_reg <= '0;
            for (int e = 0; e < MSHR_DEPTH; e++) begin
                ent_line_reg[e]    <= '0;
                ent_waiters_reg[e] <= '0;
            end
        end else begin
            for (int e = 0; e < MSHR_DEPTH; e++) begin
                if (retire_vec[e]) begin
                    ent_valid_reg[e]   <= 1'b0;
                    ent_issued_reg[e]  <= 1'b0;
                    ent_waiters_reg[e] <= '0;
                end else if (alloc_en && (alloc_idx == IDW'(e))) begin
                    ent_valid_reg[e]   <= 1'b1;
                    ent_issued_reg[e]  <= 1'b0;
                    ent_line_reg[e]    <= grant_line;
                    ent_waiters_reg[e] <= grant_onehot;
                end else begin
                    if (merge_en && (merge_idx == IDW'(e))) begin
                        ent_waiters_reg[e] <= ent_waiters_reg[e] | grant_onehot;
                    end
                    if (issue_ack && (issue_idx_reg == IDW'(e))) begin
                        ent_issued_reg[e] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg     <= '0;
            state_reg      <= IDLE;
            issue_idx_reg  <= '0;
            issue_line_reg <= '0;
            rsp_valid_reg  <= '0;
            rsp_line_reg   <= '0;
            rsp_data_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            rr_ptr_reg     <= rr_ptr_next;
            state_reg      <= state_next;
            issue_idx_reg  <= issue_idx_next;
            issue_line_reg <= issue_line_next;
            rsp_valid_reg  <= rsp_hit ? ent_waiters_reg[bus.dram_rsp_id] : '0;
            if (rsp_hit) begin
                rsp_line_reg <= ent_line_reg[bus.dram_rsp_id];
                rsp_data_reg <= bus.dram_rsp_data;
            end
            if (bus.dram_rsp_valid && !rsp_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.req_ready      = grant_onehot;
    assign bus.dram_req_valid = (state_reg == REQ);
    assign bus.dram_req_addr  = {issue_line_reg, {LINE_OFFSET{1'b0}}};
    assign bus.dram_req_id    = issue_idx_reg;
    assign bus.rsp_valid      = rsp_valid_reg;
    assign bus.rsp_addr       = {rsp_line_reg, {LINE_OFFSET{1'b0}}};
    assign bus.rsp_data       = rsp_data_reg;
    assign bus.mshr_full      = &ent_valid_reg;
    assign bus.err            = err_reg;
endmodule

// File: tb/tb_l2_miss_ctrl.sv
// Directed bench for l2_miss_ctrl with a table-level reference model compared every cycle
// plus literal expectations for the key scenarios.
module tb_l2_miss_ctrl;
    localparam int NP  = 4;
    localparam int AW  = 40;
    localparam int DW  = 64;
    localparam int LO  = 6;
    localparam int MD  = 4;
    localparam int LW  = AW - LO;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_miss_ctrl_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MSHR_DEPTH(MD)) bus ();

    l2_miss_ctrl #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_OFFSET(LO), .MSHR_DEPTH(MD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: table of misses ----------------
    typedef struct {
        bit            v;
        bit            iss;
        logic [LW-1:0] line;
        logic [NP-1:0] w;
    } ent_t;

    ent_t          m_ent [MD];
    int            m_rr;
    bit            m_drq;
    int            m_drq_id;
    logic [LW-1:0] m_drq_line;
    logic [NP-1:0] m_rsp_valid;
    logic [AW-1:0] m_rsp_addr;
    logic [DW-1:0] m_rsp_data;
    bit            m_err;
    bit            m_live = 1'b0;

    function automatic int m_retiring();
        int id;
        id = int'(bus.dram_rsp_id);
        if (bus.dram_rsp_valid && m_ent[id].v && m_ent[id].iss) return id;
        return -1;
    endfunction

    function automatic void m_arb(output int port, output int tgt, output bit merge);
        int ret, p, hit, fr;
        logic [LW-1:0] ln;
        port  = -1;
        tgt   = -1;
        merge = 1'b0;
        ret   = m_retiring();
        fr    = -1;
        for (int e = MD - 1; e >= 0; e--) if (!m_ent[e].v) fr = e;
        for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (bus.req_valid[p]) begin
                ln  = bus.req_addr[p*AW+LO +: LW];
                hit = -1;
                for (int e = MD - 1; e >= 0; e--)
                    if (m_ent[e].v && e != ret && m_ent[e].line == ln) hit = e;
                if (hit >= 0) begin
                    port = p; tgt = hit; merge = 1'b1;
                    return;
                end else if (fr >= 0) begin
                    port = p; tgt = fr;
                    return;
                end
            end
        end
    endfunction

    int mp, mt, mret, mpend;
    bit mmg, old_drq;

    always @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < MD; e++) begin
                m_ent[e].v = 0; m_ent[e].iss = 0; m_ent[e].line = '0; m_ent[e].w = '0;
            end
            m_rr = 0; m_drq = 0; m_drq_id = 0; m_drq_line = '0;
            m_rsp_valid = '0; m_rsp_addr = '0; m_rsp_data = '0; m_err = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            m_arb(mp, mt, mmg);
            mret  = m_retiring();
            mpend = -1;
            for (int e = MD - 1; e >= 0; e--) if (m_ent[e].v && !m_ent[e].iss) mpend = e;
            old_drq = m_drq;
            if (old_drq) begin
                if (bus.dram_req_ready) begin
                    m_ent[m_drq_id].iss = 1;
                    m_drq = 0;
                end
            end else if (mpend >= 0) begin
                m_drq      = 1;
                m_drq_id   = mpend;
                m_drq_line = m_ent[mpend].line;
            end
            m_rsp_valid = '0;
            if (bus.dram_rsp_valid) begin
                if (mret >= 0) begin
                    m_rsp_valid = m_ent[mret].w;
                    m_rsp_addr  = {m_ent[mret].line, {LO{1'b0}}};
                    m_rsp_data  = bus.dram_rsp_data;
                    m_ent[mret].v = 0; m_ent[mret].iss = 0; m_ent[mret].w = '0;
                end else begin
                    m_err = 1;
                end
            end
            if (mp >= 0) begin
                if (mmg) begin
                    m_ent[mt].w[mp] = 1'b1;
                end else begin
                    m_ent[mt].v    = 1;
                    m_ent[mt].iss  = 0;
                    m_ent[mt].line = bus.req_addr[mp*AW+LO +: LW];
                    m_ent[mt].w    = '0;
                    m_ent[mt].w[mp] = 1'b1;
                end
                m_rr = (mp + 1) % NP;
            end
        end
    end

    int cp, ct;
    bit cmg, cfull;
    logic [NP-1:0] c_rdy;
    int drq_hs = 0;

    always @(negedge clk) begin
        if (bus.dram_req_valid === 1'b1 && bus.dram_req_ready) drq_hs++;
        if (m_live) begin
            m_arb(cp, ct, cmg);
            c_rdy = '0;
            if (cp >= 0) c_rdy[cp] = 1'b1;
            cfull = 1;
            for (int e = 0; e < MD; e++) if (!m_ent[e].v) cfull = 0;
            chk("m_req_ready", bus.req_ready, c_rdy);
            chk("m_mshr_full", bus.mshr_full, cfull);
            chk("m_dram_req_valid", bus.dram_req_valid, m_drq);
            if (m_drq) begin
                chk("m_dram_req_addr", bus.dram_req_addr, {m_drq_line, {LO{1'b0}}});
                chk("m_dram_req_id", bus.dram_req_id, m_drq_id);
            end
            chk("m_rsp_valid", bus.rsp_valid, m_rsp_valid);
            if (m_rsp_valid != '0) begin
                chk("m_rsp_addr", bus.rsp_addr, m_rsp_addr);
                chk("m_rsp_data", bus.rsp_data, m_rsp_data);
            end
            chk("m_err", bus.err, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        bus.req_addr[p*AW +: AW] = a;
    endtask

    task automatic rsp(input bit v, input int id, input logic [DW-1:0] d);
        bus.dram_rsp_valid = v;
        bus.dram_rsp_id    = 2'(id);
        bus.dram_rsp_data  = d;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_dram_req_valid"}, bus.dram_req_valid, 0);
        chk({tag, "_dram_req_addr"}, bus.dram_req_addr, 0);
        chk({tag, "_dram_req_id"}, bus.dram_req_id, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_addr"}, bus.rsp_addr, 0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 0);
        chk({tag, "_mshr_full"}, bus.mshr_full, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    localparam logic [AW-1:0] RR_BASE = 40'h00_4000_0000;
    logic [AW-1:0] l5_addr;
    int hs0;

    initial begin
        bus.req_valid      = '0;
        bus.req_addr       = '0;
        bus.dram_req_ready = 1'b0;
        rsp(0, 0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mid();
        chk_zero("reset");

        // single miss
        cyc(); bus.req_valid = 4'b0010; set_addr(1, 40'h00_1000_0047); mid();
        chk("single_grant", bus.req_ready, 4'b0010);
        $display("single: request port1 addr 1000_0047");
        cyc(); bus.req_valid = '0; mid();
        chk("single_t1_no_req", bus.dram_req_valid, 0);
        cyc(); bus.dram_req_ready = 1'b1; mid();
        chk("single_t2_req", bus.dram_req_valid, 1);
        chk("single_t2_addr", bus.dram_req_addr, 40'h00_1000_0040);
        chk("single_t2_id", bus.dram_req_id, 0);
        cyc(); bus.dram_req_ready = 1'b0; rsp(1, 0, 64'hDEAD_BEEF); mid();
        chk("single_rsp_latency", bus.rsp_valid, 0);
        cyc(); rsp(0, 0, '0); mid();
        chk("single_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("single_rsp_addr", bus.rsp_addr, 40'h00_1000_0040);
        chk("single_rsp_data", bus.rsp_data, 64'hDEAD_BEEF);
        $display("single: refill rsp_valid=%b addr=%h", bus.rsp_valid, bus.rsp_addr);

        // merge of ports 0,2,3 onto one line, plus a repeated request from port 0
        hs0 = drq_hs;
        cyc(); bus.dram_req_ready = 1'b1; bus.req_valid = 4'b0001; set_addr(0, 40'h2004); mid();
        chk("merge_g0", bus.req_ready, 4'b0001);
        cyc(); bus.req_valid = 4'b0100; set_addr(2, 40'h2010); mid();
        chk("merge_g2", bus.req_ready, 4'b0100);
        cyc(); bus.req_valid = 4'b1000; set_addr(3, 40'h203F); mid();
        chk("merge_g3", bus.req_ready, 4'b1000);
        cyc(); bus.req_valid = 4'b0001; set_addr(0, 40'h2008); mid();
        chk("merge_repeat", bus.req_ready, 4'b0001);
        cyc(); bus.req_valid = '0; mid();
        cyc(); rsp(1, 0, 64'h1234_5678_9ABC_DEF0); mid();
        cyc(); rsp(0, 0, '0); bus.dram_req_ready = 1'b0; mid();
        chk("merge_rsp_valid", bus.rsp_valid, 4'b1101);
        chk("merge_rsp_addr", bus.rsp_addr, 40'h2000);
        chk("merge_one_dram_req", drq_hs - hs0, 1);
        $display("merge: rsp_valid=%b dram_reqs=%0d", bus.rsp_valid, drq_hs - hs0);

        // round-robin with all ports requesting fresh lines every cycle
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; bus.dram_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            bus.req_valid = 4'b1111;
            for (int p = 0; p < NP; p++) set_addr(p, RR_BASE + (40'(k * 4 + p) << LO));
            mid();
            chk("rr_grant", bus.req_ready, (k < 4) ? (4'b0001 << k) : 4'b0000);
            $display("rr: cycle %0d req_ready=%b", k, bus.req_ready);
        end
        chk("rr_full", bus.mshr_full, 1);

        // full table: new line stalls, pending line still merges
        l5_addr = RR_BASE + (40'd100 << LO);
        cyc(); bus.req_valid = 4'b0011; set_addr(0, l5_addr); set_addr(1, RR_BASE + (40'd5 << LO) + 40'd3); mid();
        chk("full_merge_pending", bus.req_ready, 4'b0010);
        for (int i = 0; i < 9; i++) begin
            cyc(); bus.req_valid = 4'b0001; mid();
            chk("full_stall", bus.req_ready, 0);
        end
        cyc(); rsp(1, 2, 64'h2222); mid();
        chk("full_retiring_not_free", bus.req_ready, 0);
        cyc(); rsp(0, 0, '0); mid();
        chk("full_rsp_id2", bus.rsp_valid, 4'b0100);
        chk("full_fifth_accept", bus.req_ready, 4'b0001);
        cyc(); bus.req_valid = '0; mid();
        chk("full_realloc_t1", bus.dram_req_valid, 0);
        cyc(); mid();
        chk("full_realloc_req", bus.dram_req_valid, 1);
        chk("full_realloc_id", bus.dram_req_id, 2);
        chk("full_realloc_addr", bus.dram_req_addr, l5_addr);
        $display("full: fifth line reissued id=%0d", bus.dram_req_id);
        for (int i = 0; i < 4; i++) begin
            cyc(); rsp(1, i, 64'(64'hA0 + i)); mid();
        end
        cyc(); rsp(0, 0, '0); mid();

        // backpressure: id1 held while entry 0 is freed and re-allocated below it
        cyc(); bus.dram_req_ready = 1'b1; bus.req_valid = 4'b0001; set_addr(0, 40'h12_3456_7800); mid();
        chk("bp_g0", bus.req_ready, 4'b0001);
        cyc(); bus.req_valid = 4'b0010; set_addr(1, 40'h00_ABCD_EF40); mid();
        chk("bp_g1", bus.req_ready, 4'b0010);
        cyc(); bus.req_valid = '0; mid();
        chk("bp_first_id", bus.dram_req_id, 0);
        cyc(); bus.dram_req_ready = 1'b0; mid();
        for (int i = 0; i < 10; i++) begin
            cyc();
            rsp(i == 0, 0, 64'h0BAD_F00D);
            bus.req_valid = (i == 1) ? 4'b0100 : 4'b0000;
            set_addr(2, 40'h00_0000_C0C0);
            mid();
            chk("bp_valid", bus.dram_req_valid, 1);
            chk("bp_id", bus.dram_req_id, 1);
            chk("bp_addr", bus.dram_req_addr, 40'h00_ABCD_EF40);
            if (i == 1) begin
                chk("bp_low_alloc", bus.req_ready, 4'b0100);
                chk("bp_rsp0", bus.rsp_valid, 4'b0001);
            end
        end
        $display("bp: stalled id=%0d addr=%h", bus.dram_req_id, bus.dram_req_addr);
        cyc(); bus.dram_req_ready = 1'b1; mid();
        chk("bp_release", bus.dram_req_valid, 1);
        cyc(); mid();
        chk("bp_gap", bus.dram_req_valid, 0);
        cyc(); mid();
        chk("bp_next_id", bus.dram_req_id, 0);
        chk("bp_next_addr", bus.dram_req_addr, 40'h00_0000_C0C0);
        cyc(); bus.dram_req_ready = 1'b0; rsp(1, 1, 64'h11); mid();
        cyc(); rsp(1, 0, 64'h22); mid();
        chk("bp_rsp1", bus.rsp_valid, 4'b0010);
        cyc(); rsp(0, 0, '0); mid();
        chk("bp_rsp2", bus.rsp_valid, 4'b0100);

        // errors and reset mid-operation
        cyc(); rsp(1, 3, 64'h33); mid();
        cyc(); rsp(0, 0, '0); mid();
        chk("err_set", bus.err, 1);
        chk("err_no_rsp", bus.rsp_valid, 0);
        cyc(); bus.req_valid = 4'b0001; set_addr(0, 40'h00_0001_0000); mid();
        chk("err_sticky", bus.err, 1);
        cyc(); bus.req_valid = 4'b0010; set_addr(1, 40'h00_0002_0000); mid();
        cyc(); bus.req_valid = '0; mid();
        chk("pre_rst_req", bus.dram_req_valid, 1);
        cyc(); rst = 1'b1; mid();
        cyc(); rst = 1'b0; mid();
        chk_zero("midrst");
        $display("reset: outputs cleared err=%0d", bus.err);
        cyc(); rsp(1, 0, 64'h44); mid();
        cyc(); rsp(0, 0, '0); mid();
        chk("post_rst_err", bus.err, 1);
        chk("post_rst_no_rsp", bus.rsp_valid, 0);
        cyc(); mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
